// File: rtl/slip_frame_parser_pkg.sv
// Shared constants, FSM state type and the CRC-8 step used by the SLIP frame parser.
package slip_pkg;

  localparam logic [7:0] CRC8_POLY = 8'h07;

  localparam logic [1:0] ERR_SHORT = 2'd1;
  localparam logic [1:0] ERR_OVF   = 2'd2;
  localparam logic [1:0] ERR_CRC   = 2'd3;

  typedef enum logic [1:0] {
    ST_COLLECT,
    ST_CHECK,
    ST_EMIT
  } state_t;

  // One byte of CRC-8 (poly 0x07, MSB first, no reflection, no xorout).
  function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] b);
    logic [7:0] c;
    c = crc ^ b;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ({c[6:0], 1'b0} ^ CRC8_POLY) : {c[6:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/slip_frame_parser.sv
// Buffers one SLIP frame (address, data, CRC-8), validates it, then replays the
// data as a burst of byte writes. Bad frames are dropped with an error code.
module slip_frame_parser
  import slip_pkg::*;
#(
  parameter int MAX_DATA = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame,
  input  logic [7:0] din,
  input  logic       din_rdy,
  output logic       din_ack,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       wr_valid,
  input  logic       wr_ready,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code
);

  localparam int DEPTH = MAX_DATA + 1;          // data bytes plus the CRC byte
  localparam int CW    = $clog2(MAX_DATA + 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(MAX_DATA + 1);

  state_t          state_q;
  logic [7:0]      addr_q;
  logic [7:0]      buf_q [DEPTH];
  logic [CW-1:0]   cnt_q, idx_q, last_q;
  logic [7:0]      crc_q;
  logic            ovf_q, in_frame_q, got_q;  // got_q: address byte already taken
  logic            wr_valid_q, frame_ok_q, frame_err_q;
  logic [7:0]      wr_addr_q, wr_data_q;
  logic [1:0]      err_code_q;

  logic            take, eof, beat;
  logic [7:0]      crc_d;
  logic [CW-1:0]   idx_d;

  // Input is only accepted while collecting; upstream holds its byte otherwise.
  assign din_ack = (state_q == ST_COLLECT) && din_rdy;
  assign take    = din_ack;
  assign crc_d   = crc8_byte(crc_q, din);
  // Requiring din_rdy low guarantees a pending final byte is drained first.
  assign eof     = (state_q == ST_COLLECT) && (in_frame_q || got_q) && !frame && !din_rdy;
  assign beat    = wr_valid_q && wr_ready;
  assign idx_d   = idx_q + CW'(1);

  assign wr_valid  = wr_valid_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign frame_ok  = frame_ok_q;
  assign frame_err = frame_err_q;
  assign err_code  = err_code_q;

  // Payload store: bytes after the address, discarded once the buffer is full.
  always_ff @(posedge clk) begin
    if (take && got_q && (cnt_q != CNT_FULL)) buf_q[cnt_q] <= din;
  end

  // Frame FSM: collect, validate, then emit the write burst.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_COLLECT;
      addr_q      <= '0;
      cnt_q       <= '0;
      idx_q       <= '0;
      last_q      <= '0;
      crc_q       <= '0;
      ovf_q       <= 1'b0;
      in_frame_q  <= 1'b0;
      got_q       <= 1'b0;
      wr_valid_q  <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      err_code_q  <= '0;
    end else begin
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      case (state_q)
        ST_COLLECT: begin
          if (frame) in_frame_q <= 1'b1;
          if (take) begin
            crc_q <= crc_d;
            got_q <= 1'b1;
            if (!got_q)                addr_q <= din;
            else if (cnt_q == CNT_FULL) ovf_q  <= 1'b1;
            else                        cnt_q  <= cnt_q + CW'(1);
          end
          if (eof) state_q <= ST_CHECK;
        end
        ST_CHECK: begin
          if (ovf_q || (cnt_q < CW'(2)) || (crc_q != 8'h00)) begin
            frame_err_q <= 1'b1;
            err_code_q  <= ovf_q ? ERR_OVF : ((cnt_q < CW'(2)) ? ERR_SHORT : ERR_CRC);
            cnt_q       <= '0;
            crc_q       <= '0;
            ovf_q       <= 1'b0;
            in_frame_q  <= 1'b0;
            got_q       <= 1'b0;
            state_q     <= ST_COLLECT;
          end else begin
            idx_q      <= '0;
            last_q     <= cnt_q - CW'(2);
            wr_valid_q <= 1'b1;
            wr_addr_q  <= addr_q;
            wr_data_q  <= buf_q[0];
            state_q    <= ST_EMIT;
          end
        end
        ST_EMIT: begin
          if (beat) begin
            if (idx_q == last_q) begin
              wr_valid_q <= 1'b0;
              frame_ok_q <= 1'b1;
              cnt_q      <= '0;
              crc_q      <= '0;
              ovf_q      <= 1'b0;
              in_frame_q <= 1'b0;
              got_q      <= 1'b0;
              state_q    <= ST_COLLECT;
            end else begin
              idx_q     <= idx_d;
              wr_addr_q <= addr_q + 8'(idx_d);
              wr_data_q <= buf_q[idx_d];
            end
          end
        end
        default: state_q <= ST_COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_slip_frame_parser.sv
// Scoreboard bench for slip_frame_parser: a frame model pushes expected writes
// and outcomes when a frame is driven; a negedge monitor pops and compares.
module tb_slip_frame_parser;

  localparam int MAX_DATA = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame = 1'b0;
  logic [7:0] din = 8'h00;
  logic       din_rdy = 1'b0;
  logic       wr_ready = 1'b1;
  logic       din_ack, wr_valid, frame_ok, frame_err;
  logic [7:0] wr_addr, wr_data;
  logic [1:0] err_code;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] d;
  } wr_t;

  wr_t wq[$];   // expected write beats
  int  eq[$];   // expected outcome: 0 = ok, else error code

  slip_frame_parser #(.MAX_DATA(MAX_DATA)) dut (
    .clk(clk), .rst(rst), .frame(frame), .din(din), .din_rdy(din_rdy),
    .din_ack(din_ack), .wr_addr(wr_addr), .wr_data(wr_data), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .frame_ok(frame_ok), .frame_err(frame_err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] crc_of(input logic [7:0] b[$]);
    logic [7:0] c;
    logic       fb;
    c = 8'h00;
    foreach (b[k]) begin
      for (int i = 7; i >= 0; i--) begin
        fb = c[7] ^ b[k][i];
        c  = {c[6:0], 1'b0};
        if (fb) c = c ^ 8'h07;
      end
    end
    return c;
  endfunction

  // Expected outcome of a frame, by precedence overflow > short > CRC.
  task automatic model(input logic [7:0] b[$]);
    int n;
    n = b.size();
    if (n - 1 > MAX_DATA + 1)   eq.push_back(2);
    else if (n < 3)             eq.push_back(1);
    else if (crc_of(b) != 8'h00) eq.push_back(3);
    else begin
      for (int i = 0; i < n - 2; i++) wq.push_back(wr_t'({b[0] + 8'(i), b[i+1]}));
      eq.push_back(0);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    din = b;
    din_rdy = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (din_ack) begin ok = 1'b1; break; end
    end
    if (!ok) chk("ack_timeout", 0, 1);
    @(posedge clk); #1;
    din_rdy = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b[$], input bit mdl);
    if (mdl) model(b);
    frame = 1'b1;
    foreach (b[k]) send_byte(b[k]);
    frame = 1'b0;
  endtask

  task automatic wait_done();
    for (int t = 0; t < 400; t++) begin
      @(posedge clk); #2;
      if (wq.size() == 0 && eq.size() == 0) break;
    end
    chk("drain_wr", wq.size(), 0);
    chk("drain_ev", eq.size(), 0);
  endtask

  // Monitor: compare beats and pulses against the scoreboard, check stall hold.
  logic       stall_q = 1'b0;
  logic [7:0] pa = 8'h00, pd = 8'h00;
  always @(negedge clk) begin
    wr_t e;
    int  x;
    if (rst) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        chk("hold_addr", wr_addr, pa);
        chk("hold_data", wr_data, pd);
      end
      if (wr_valid) chk("ack_in_emit", din_ack, 0);
      if (wr_valid && wr_ready) begin
        if (wq.size() == 0) chk("unexp_wr", 1, 0);
        else begin
          e = wq.pop_front();
          chk("wr_addr", wr_addr, e.a);
          chk("wr_data", wr_data, e.d);
        end
      end
      stall_q = wr_valid && !wr_ready;
      pa = wr_addr;
      pd = wr_data;
      if (frame_ok && frame_err) chk("ok_err_excl", 1, 0);
      if (frame_ok) begin
        if (eq.size() == 0) chk("unexp_ok", 1, 0);
        else begin x = eq.pop_front(); chk("frame_ok", 0, x); end
      end
      if (frame_err) begin
        if (eq.size() == 0) chk("unexp_err", 1, 0);
        else begin x = eq.pop_front(); chk("err_code", err_code, x); end
      end
    end
  end

  initial begin
    logic [7:0] f[$];
    bit         seen;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", wr_valid, 0);
    chk("rst_ok", frame_ok, 0);
    chk("rst_err", frame_err, 0);
    chk("rst_code", err_code, 0);
    chk("rst_addr", wr_addr, 0);
    chk("rst_data", wr_data, 0);
    chk("rst_ack", din_ack, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Good single-byte frame, then CRC error, then two short frames.
    f = '{8'h10, 8'hAA, 8'h08}; send_frame(f, 1); wait_done();
    f = '{8'h10, 8'hAA, 8'h09}; send_frame(f, 1); wait_done();
    f = '{8'h10};               send_frame(f, 1); wait_done();
    f = '{8'h10, 8'h70};        send_frame(f, 1); wait_done();

    // Overflow with good tail CRC and with bad tail CRC.
    for (int v = 0; v < 2; v++) begin
      f = '{8'h30};
      for (int i = 0; i <= MAX_DATA; i++) f.push_back(8'(8'h40 + i));
      f.push_back(crc_of(f) ^ 8'(v));
      send_frame(f, 1);
      wait_done();
    end

    // Address wrap with back-pressure; next frame's byte waits through EMIT.
    f = '{8'hFF, 8'h01, 8'h02};
    f.push_back(crc_of(f));
    send_frame(f, 1);
    @(posedge clk); #1;
    fork
      begin
        logic [7:0] g[$];
        g = '{8'h10, 8'hAA, 8'h08};
        send_frame(g, 1);
      end
      begin
        seen = 1'b0;
        for (int t = 0; t < 50; t++) begin
          @(negedge clk);
          if (wr_valid) begin seen = 1'b1; break; end
        end
        chk("stall_reach_emit", seen, 1);
        @(posedge clk); #1 wr_ready = 1'b0;
        @(posedge clk);
        @(posedge clk); #1 wr_ready = 1'b1;
      end
    join
    wait_done();

    // Random good frames at full throughput.
    for (int r = 0; r < 3; r++) begin
      int n;
      n = $urandom_range(MAX_DATA, 1);
      f = '{8'($urandom)};
      for (int i = 0; i < n; i++) f.push_back(8'($urandom));
      f.push_back(crc_of(f));
      send_frame(f, 1);
      wait_done();
    end

    // Reset in the middle of a stalled burst aborts it silently.
    wr_ready = 1'b0;
    f = '{8'h20, 8'h01, 8'h02, 8'h03};
    f.push_back(crc_of(f));
    send_frame(f, 0);
    seen = 1'b0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (wr_valid) begin seen = 1'b1; break; end
    end
    chk("rst_reach_emit", seen, 1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_drop_valid", wr_valid, 0);
    chk("rst_drop_addr", wr_addr, 0);
    wr_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("rst_no_valid", wr_valid, 0);
    f = '{8'h10, 8'hAA, 8'h08}; send_frame(f, 1); wait_done();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
